sram_seq: RTL and testbench

//  Hardware sequencer for the external asynchronous SRAM (8-bit data, 18-bit address).

---
 rtl/sram_seq_pkg.sv | 18 +
 rtl/sram_seq_tcnt.sv | 23 ++
 rtl/sram_seq.sv | 152 +++++++++++++++
 tb/tb_sram_seq.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_seq_pkg.sv
// rtl/sram_seq_pkg.sv - shared state encodings and phase-counter helpers for sram_seq
package sram_seq_pkg;

  localparam int TCNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_HOLD   = 2'd3
  } state_t;

  // Phase length N is counted as N-1 down to 0; zero-length phases are never loaded.
  function automatic logic [TCNT_W-1:0] tcnt_load(input int cycles);
    return (cycles > 0) ? TCNT_W'(cycles - 1) : '0;
  endfunction

endpackage

// File: rtl/sram_seq_tcnt.sv
// rtl/sram_seq_tcnt.sv - loadable phase down-counter with zero flag (module sram_tcnt)
import sram_seq_pkg::*;

module sram_tcnt (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [TCNT_W-1:0] load_val,
  output logic              zero
);

  logic [TCNT_W-1:0] cnt;

  // Load wins over counting; the counter parks at zero until reloaded.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)              cnt <= '0;
    else if (load)        cnt <= load_val;
    else if (cnt != '0)   cnt <= cnt - 1'b1;
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/sram_seq.sv
// rtl/sram_seq.sv - timed single-byte async SRAM read/write sequencer; SRAM_AUTOINC_EN adds an address pointer
import sram_seq_pkg::*;

module sram_seq #(
  parameter int ADDR_W  = 18,
  parameter int DATA_W  = 8,
  parameter int T_SETUP = 1,
  parameter int T_PULSE = 2,
  parameter int T_HOLD  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef SRAM_AUTOINC_EN
  input  logic              addr_ld,
  output logic [ADDR_W-1:0] ptr_q,
`endif
  output logic              ready,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d_o,
  output logic              sram_d_oe,
  input  logic [DATA_W-1:0] sram_d_i,
  output logic              sram_ncs,
  output logic              sram_nwe,
  output logic              sram_noe
);

  localparam logic              HAS_SETUP = (T_SETUP > 0);
  localparam logic              HAS_HOLD  = (T_HOLD > 0);
  localparam logic [TCNT_W-1:0] LD_SETUP  = tcnt_load(T_SETUP);
  localparam logic [TCNT_W-1:0] LD_PULSE  = tcnt_load(T_PULSE);
  localparam logic [TCNT_W-1:0] LD_HOLD   = tcnt_load(T_HOLD);

  state_t              state, state_nx;
  logic                cnt_load, cnt_zero;
  logic [TCNT_W-1:0]   cnt_val;
  logic                accept;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q, acc_addr;
  logic [DATA_W-1:0]   wdata_q;

  assign accept = req && (state == S_IDLE);

`ifdef SRAM_AUTOINC_EN
  logic [ADDR_W-1:0] ptr;

  assign acc_addr = addr_ld ? addr : ptr;
  assign ptr_q    = ptr;

  // Pointer always lands one past the address just used, wrapping naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= acc_addr + 1'b1;
  end
`else
  assign acc_addr = addr;
`endif

  sram_tcnt u_tcnt (
    .clk      (clk),
    .rst      (reset),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  // State register; reset drops straight to IDLE so all strobes release at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next state and phase-counter reload on every state entry.
  always_comb begin
    state_nx = state;
    cnt_load = 1'b0;
    cnt_val  = LD_PULSE;
    case (state)
      S_IDLE: begin
        if (req) begin
          cnt_load = 1'b1;
          if (HAS_SETUP) begin
            state_nx = S_SETUP;
            cnt_val  = LD_SETUP;
          end else begin
            state_nx = S_STROBE;
          end
        end
      end
      S_SETUP: begin
        if (cnt_zero) begin
          state_nx = S_STROBE;
          cnt_load = 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_zero) begin
          if (HAS_HOLD) begin
            state_nx = S_HOLD;
            cnt_load = 1'b1;
            cnt_val  = LD_HOLD;
          end else begin
            state_nx = S_IDLE;
          end
        end
      end
      default: begin
        if (cnt_zero) state_nx = S_IDLE;
      end
    endcase
  end

  // Pin strobes decoded from state only, so they follow the async reset immediately.
  always_comb begin
    ready     = (state == S_IDLE);
    sram_ncs  = (state == S_IDLE);
    sram_d_oe = we_q && (state != S_IDLE);
    sram_nwe  = !(we_q && (state == S_STROBE));
    sram_noe  = !(!we_q && (state == S_STROBE));
  end

  assign sram_a   = addr_q;
  assign sram_d_o = wdata_q;

  // Request latch on accept; read data captured on the final strobe cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rvalid  <= 1'b0;
      rdata   <= '0;
    end else begin
      rvalid <= 1'b0;
      if (accept) begin
        we_q    <= we;
        addr_q  <= acc_addr;
        wdata_q <= wdata;
      end
      if ((state == S_STROBE) && cnt_zero && !we_q) begin
        rdata  <= sram_d_i;
        rvalid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sram_seq.sv
// tb/tb_sram_seq.sv - scoreboard bench for sram_seq (default and fast timing; SRAM_AUTOINC_EN aware)
module tb_sram_seq;

  localparam int AW = 18;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          req = 1'b0, we = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [DW-1:0] wdata = '0;
  logic          ready, rvalid, sram_d_oe, sram_ncs, sram_nwe, sram_noe;
  logic [DW-1:0] rdata, sram_d_o, sram_d_i;
  logic [AW-1:0] sram_a;

  logic          req2 = 1'b0, we2 = 1'b0;
  logic [AW-1:0] addr2 = '0;
  logic [DW-1:0] wdata2 = '0;
  logic          ready2, rvalid2, sram_d_oe2, sram_ncs2, sram_nwe2, sram_noe2;
  logic [DW-1:0] rdata2, sram_d_o2, sram_d_i2;
  logic [AW-1:0] sram_a2;

`ifdef SRAM_AUTOINC_EN
  logic          addr_ld = 1'b1;
  logic          addr_ld2 = 1'b1;
  logic [AW-1:0] ptr_q, ptr_q2;
`endif

  sram_seq dut (
    .clk(clk), .reset(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef SRAM_AUTOINC_EN
    .addr_ld(addr_ld), .ptr_q(ptr_q),
`endif
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .sram_a(sram_a),
    .sram_d_o(sram_d_o), .sram_d_oe(sram_d_oe), .sram_d_i(sram_d_i),
    .sram_ncs(sram_ncs), .sram_nwe(sram_nwe), .sram_noe(sram_noe)
  );

  sram_seq #(.T_SETUP(0), .T_PULSE(1), .T_HOLD(0)) dut2 (
    .clk(clk), .reset(rst), .req(req2), .we(we2), .addr(addr2), .wdata(wdata2),
`ifdef SRAM_AUTOINC_EN
    .addr_ld(addr_ld2), .ptr_q(ptr_q2),
`endif
    .ready(ready2), .rvalid(rvalid2), .rdata(rdata2), .sram_a(sram_a2),
    .sram_d_o(sram_d_o2), .sram_d_oe(sram_d_oe2), .sram_d_i(sram_d_i2),
    .sram_ncs(sram_ncs2), .sram_nwe(sram_nwe2), .sram_noe(sram_noe2)
  );

  // SRAM models
  logic [DW-1:0] mem  [0:(1<<AW)-1];
  logic [DW-1:0] mem2 [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_ncs && !sram_nwe && sram_d_oe) mem[sram_a] <= sram_d_o;
    if (!sram_ncs2 && !sram_nwe2 && sram_d_oe2) mem2[sram_a2] <= sram_d_o2;
  end
  assign sram_d_i  = !sram_noe  ? mem[sram_a]   : '0;
  assign sram_d_i2 = !sram_noe2 ? mem2[sram_a2] : '0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [AW-1:0] a;
    int ncs;
    int nwe;
    int noe;
    int doe;
  } acc_t;

  acc_t          exp_acc[$];
  logic [DW-1:0] exp_rd[$];
  logic [DW-1:0] exp_rd2[$];
  logic [AW-1:0] exp_ptr = '0;

  // Monitor: per-access pin timing on dut, read-data scoreboards, pin invariants
  acc_t cur;
  bit   in_acc = 0;
  always @(negedge clk) begin
    check("nwe_noe_exclusive", {31'd0, sram_nwe | sram_noe}, 32'd1);
    check("doe_vs_noe", {31'd0, sram_d_oe & ~sram_noe}, 32'd0);
    check("nwe_noe_exclusive2", {31'd0, sram_nwe2 | sram_noe2}, 32'd1);
    if (!sram_ncs) begin
      if (!in_acc) begin
        in_acc  = 1;
        cur.a   = sram_a;
        cur.ncs = 0; cur.nwe = 0; cur.noe = 0; cur.doe = 0;
      end
      check("addr_stable", sram_a, cur.a);
      cur.ncs++;
      if (!sram_nwe) cur.nwe++;
      if (!sram_noe) cur.noe++;
      if (sram_d_oe) cur.doe++;
    end else if (in_acc) begin
      acc_t e;
      in_acc = 0;
      if (exp_acc.size() == 0) begin
        check("unexpected_access", 32'd1, 32'd0);
      end else begin
        e = exp_acc.pop_front();
        check("acc_addr", cur.a, e.a);
        check("ncs_cycles", cur.ncs, e.ncs);
        check("nwe_cycles", cur.nwe, e.nwe);
        check("noe_cycles", cur.noe, e.noe);
        check("doe_cycles", cur.doe, e.doe);
      end
    end
    if (rvalid) begin
      if (exp_rd.size() == 0) check("unexpected_rvalid", 32'd1, 32'd0);
      else check("rdata", rdata, exp_rd.pop_front());
    end
    if (rvalid2) begin
      if (exp_rd2.size() == 0) check("unexpected_rvalid2", 32'd1, 32'd0);
      else check("rdata2", rdata2, exp_rd2.pop_front());
    end
  end

  // Push the expected pin record for one dut access (abort = reset during first STROBE cycle)
  task automatic push_acc(input logic w, input logic [AW-1:0] a, input logic ld, input bit abort);
    acc_t e;
    e.a   = ld ? a : exp_ptr;
    exp_ptr = e.a + 1'b1;
    if (abort) begin
      e.ncs = 1; e.nwe = 0; e.noe = 0; e.doe = 0;
    end else begin
      e.ncs = 4;
      e.nwe = w ? 2 : 0;
      e.noe = w ? 0 : 2;
      e.doe = w ? 4 : 0;
    end
    exp_acc.push_back(e);
  endtask

  // For reads, d is the byte the SRAM model should return
  task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic ld, input bit abort);
    int k = 0;
    @(negedge clk);
    while (!ready && k < 50) begin @(negedge clk); k++; end
    if (!ready) check("ready_timeout", 32'd0, 32'd1);
    req = 1'b1; we = w; addr = a; wdata = d;
`ifdef SRAM_AUTOINC_EN
    addr_ld = ld;
`endif
    push_acc(w, a, ld, abort);
    if (!w && !abort) exp_rd.push_back(d);
    @(posedge clk);
    #1 req = 1'b0;
  endtask

  task automatic issue2(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int k = 0;
    @(negedge clk);
    while (!ready2 && k < 50) begin @(negedge clk); k++; end
    if (!ready2) check("ready2_timeout", 32'd0, 32'd1);
    req2 = 1'b1; we2 = w; addr2 = a; wdata2 = d;
    if (!w) exp_rd2.push_back(d);
    @(posedge clk);
    #1 req2 = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; returns cycles until the next accept is possible
  task automatic wait_ready(output int cyc);
    cyc = 1;
    while (!ready && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  task automatic wait_ready2(output int cyc);
    cyc = 1;
    while (!ready2 && cyc < 60) begin @(posedge clk); #1; cyc++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check("reset_ctrl_in_reset", {26'd0, ready, rvalid, sram_ncs, sram_nwe, sram_noe, sram_d_oe}, 32'b101110);
    rst = 1'b0;
    @(negedge clk); #1;
    check("reset_ctrl", {26'd0, ready, rvalid, sram_ncs, sram_nwe, sram_noe, sram_d_oe}, 32'b101110);
    check("reset_rdata", rdata, 32'h0);
    check("reset_sram_a", sram_a, 32'h0);
    check("reset_sram_d_o", sram_d_o, 32'h0);
`ifdef SRAM_AUTOINC_EN
    check("reset_ptr", ptr_q, 32'h0);
`endif

    // default-timing write then read of 0x00123
    issue(1'b1, 18'h00123, 8'hA5, 1'b1, 0); wait_ready(c); check("wr_latency", c, 5);
    issue(1'b0, 18'h00123, 8'hA5, 1'b1, 0); wait_ready(c); check("rd_latency", c, 5);

    // req held through a busy access while addr/data change: two accesses, second after ready
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 18'h00456; wdata = 8'h3C;
    push_acc(1'b1, 18'h00456, 1'b1, 0);
    push_acc(1'b1, 18'h00789, 1'b1, 0);
    @(posedge clk);
    #1 addr = 18'h00789; wdata = 8'hC3;
    wait_ready(c); check("held_first_latency", c, 5);
    @(posedge clk);
    #1 req = 1'b0;
    check("held_second_accepted", {31'd0, ready}, 32'd0);
    wait_ready(c); check("held_second_latency", c, 5);
    issue(1'b0, 18'h00456, 8'h3C, 1'b1, 0);
    issue(1'b0, 18'h00789, 8'hC3, 1'b1, 0);
    wait_ready(c);
    repeat (3) @(posedge clk);
    #1 check("rdata_hold", rdata, 32'hC3);

    // reset asserted during the first STROBE cycle of a read
    issue(1'b0, 18'h00123, 8'hA5, 1'b1, 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check("abort_pins", {29'd0, sram_ncs, sram_noe, sram_d_oe}, 32'b110);
    check("abort_rvalid", {31'd0, rvalid}, 32'd0);
    exp_ptr = '0;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("abort_ready", {31'd0, ready}, 32'd1);
    repeat (6) @(posedge clk);

    // normal operation resumes after the abort
    issue(1'b1, 18'h00001, 8'h77, 1'b1, 0);
    issue(1'b0, 18'h00001, 8'h77, 1'b1, 0);
    wait_ready(c); check("post_abort_latency", c, 5);

    // fast timing: back-to-back write/read at top address
    issue2(1'b1, 18'h3FFFF, 8'h5A); wait_ready2(c); check("fast_wr_latency", c, 2);
    issue2(1'b0, 18'h3FFFF, 8'h5A); wait_ready2(c); check("fast_rd_latency", c, 2);
    issue2(1'b1, 18'h00000, 8'hE1);
    issue2(1'b0, 18'h00000, 8'hE1);
    issue2(1'b0, 18'h3FFFF, 8'h5A);
    wait_ready2(c);

`ifdef SRAM_AUTOINC_EN
    // pointer load then two auto-incrementing writes across the wrap
    issue(1'b1, 18'h3FFFE, 8'h01, 1'b1, 0);
    issue(1'b1, 18'h00ABC, 8'h02, 1'b0, 0);
    issue(1'b1, 18'h12345, 8'h03, 1'b0, 0);
    wait_ready(c);
    check("ptr_after_wrap", ptr_q, 32'h00001);
    issue(1'b0, 18'h3FFFF, 8'h02, 1'b1, 0);
    issue(1'b0, 18'h00000, 8'h03, 1'b1, 0);
    wait_ready(c);
    check("ptr_after_load", ptr_q, 32'h00001);
`endif

    repeat (10) @(posedge clk);
    check("acc_queue_drained", exp_acc.size(), 32'd0);
    check("rd_queue_drained", exp_rd.size(), 32'd0);
    check("rd2_queue_drained", exp_rd2.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
